// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one single-port SPRAM (1-cycle read
// latency, active-low write strobe) between NUM_MASTERS requesters.
// Grant is combinational from REQ and a registered priority pointer. Read data
// is returned one cycle after the grant, tagged by a registered one-hot RVALID.
// Optional feature macro: MEMARB_LOCK_EN. When it is defined, a master holding
// REQ&LOCK keeps its grant for up to LOCK_MAX consecutive grants.
// Valid/ready contract: a master raises REQ and holds it, together with WR, ADDR
// and WDATA, until it sees GNT. The access is taken on the rising edge where
// REQ&GNT is high. Dropping REQ before that edge withdraws the request.
module memory_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NUM_MASTERS  = 3,
  parameter int LOCK_MAX     = 16
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_MASTERS-1:0]              REQ,
  input  logic [NUM_MASTERS-1:0]              WR,
  input  logic [NUM_MASTERS*ADDRESS_BITS-1:0] ADDR,
  input  logic [NUM_MASTERS*BITS-1:0]         WDATA,
  input  logic [NUM_MASTERS-1:0]              LOCK,
  output logic [NUM_MASTERS-1:0]              GNT,
  output logic [BITS-1:0]                     RDATA,
  output logic [NUM_MASTERS-1:0]              RVALID,
  output logic [ADDRESS_BITS-1:0]             MEM_ADDRESS,
  output logic [BITS-1:0]                     MEM_DATA_IN,
  output logic                                MEM_WRb,
  input  logic [BITS-1:0]                     MEM_DATA_OUT
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
  logic [PTR_W:0]         sum;
  logic [PTR_W-1:0]       cand;

`ifdef MEMARB_LOCK_EN
  logic                   owner_vld_q, owner_vld_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   lock_hit;
`else
  logic                   unused_lock;
  assign unused_lock = ^LOCK;
`endif

  // Arbitration: the locked owner wins if allowed, otherwise the first requester from ptr upward.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_MASTERS)) sum = sum - (PTR_W+1)'(NUM_MASTERS);
      cand = sum[PTR_W-1:0];
      if (!gnt_any && REQ[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef MEMARB_LOCK_EN
    // lock_cnt_q counts locked regrants, so the owner gets LOCK_MAX grants in a row at most.
    lock_hit = owner_vld_q && REQ[owner_q] && LOCK[owner_q] &&
               (lock_cnt_q < CNT_W'(LOCK_MAX - 1));
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end
`endif
    if (RST) gnt_any = 1'b0;
  end

  // Memory-side mux and grant vector; idle bus when nothing is granted, so no spurious writes.
  always_comb begin
    GNT         = '0;
    MEM_ADDRESS = '0;
    MEM_DATA_IN = '0;
    MEM_WRb     = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_any && (gnt_idx == PTR_W'(i))) begin
        GNT[i]      = 1'b1;
        MEM_ADDRESS = ADDR[i*ADDRESS_BITS +: ADDRESS_BITS];
        MEM_DATA_IN = WDATA[i*BITS +: BITS];
        MEM_WRb     = ~WR[i];
      end
    end
  end

  // Next-state: pointer rotates past the winner; a granted read tags RVALID for the next cycle.
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if ((gnt_idx == PTR_W'(i)) && !WR[i]) rvalid_d[i] = 1'b1;
      end
    end
`ifdef MEMARB_LOCK_EN
    owner_vld_d = gnt_any;
    owner_d     = gnt_any ? gnt_idx : owner_q;
    lock_cnt_d  = (gnt_any && lock_hit) ? lock_cnt_q + 1'b1 : '0;
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q       <= '0;
      rvalid_q    <= '0;
`ifdef MEMARB_LOCK_EN
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      rvalid_q    <= rvalid_d;
`ifdef MEMARB_LOCK_EN
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  // A reset arriving while a read is in flight drops its RVALID immediately.
  assign RVALID = RST ? '0 : rvalid_q;
  assign RDATA  = MEM_DATA_OUT;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: SPRAM model, scoreboard of expected read returns,
// one task per scenario. Lock expectations follow MEMARB_LOCK_EN.
module tb_memory_arbiter;
  localparam int N  = 3;
  localparam int B  = 16;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0, wr = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*B-1:0]  wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [B-1:0]    rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]   mem_address;
  logic            mem_wrb;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [B-1:0] mem    [0:65535];
  logic [B-1:0] shadow [0:65535];
  // entry: {due cycle[31:0], master[7:0], data[15:0]}
  logic [55:0]  exp_q[$];
  logic [55:0]  e;

  memory_arbiter #(.BITS(B), .ADDRESS_BITS(AW), .NUM_MASTERS(N), .LOCK_MAX(4)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .WR(wr), .ADDR(addr), .WDATA(wdata), .LOCK(lock),
    .GNT(gnt), .RDATA(rdata), .RVALID(rvalid), .MEM_ADDRESS(mem_address),
    .MEM_DATA_IN(mem_data_in), .MEM_WRb(mem_wrb), .MEM_DATA_OUT(mem_data_out)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPRAM model: registered read, active-low write
  always @(posedge clk) begin
    if (!mem_wrb) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  // scoreboard: every cycle either an expected read return or no RVALID at all
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0][55:24] == 32'(cyc)) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rvalid !== (3'b001 << e[23:16]) || rdata !== e[15:0]) begin
          n_fail++;
          $display("FAIL sb_read cycle %0d: rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                   cyc, rvalid, rdata, 3'b001 << e[23:16], e[15:0]);
        end
      end else begin
        n_checks++;
        if (rvalid !== 3'b000) begin
          n_fail++;
          $display("FAIL sb_spurious cycle %0d: rvalid=%b, expected 000", cyc, rvalid);
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit r, input bit w, input bit l,
                       input logic [AW-1:0] a, input logic [B-1:0] d);
    req[i] = r;
    wr[i]  = w;
    lock[i] = l;
    addr[i*AW +: AW] = a;
    wdata[i*B +: B]  = d;
  endtask

  task automatic idle();
    req  = '0;
    wr   = '0;
    lock = '0;
  endtask

  // record the effect of a grant the bench predicts for master g this cycle
  task automatic account(input int g);
    logic [AW-1:0] a;
    a = addr[g*AW +: AW];
    if (wr[g]) shadow[a] = wdata[g*B +: B];
    else exp_q.push_back({32'(cyc + 1), 8'(g), shadow[a]});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle();
    exp_q.delete();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1, 1, 0, 16'h0020, 16'h1234 + 16'(i));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b expected 000", gnt); end
      n_checks++;
      if (mem_wrb !== 1'b1) begin n_fail++; $display("FAIL rst_wrb: got %b expected 1", mem_wrb); end
      n_checks++;
      if (mem_address !== 16'h0000 || mem_data_in !== 16'h0000) begin
        n_fail++;
        $display("FAIL rst_bus: addr=%h data=%h expected 0000 0000", mem_address, mem_data_in);
      end
      n_checks++;
      if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 000", rvalid); end
      next_cycle();
    end
    n_checks++;
    if (mem[16'h0020] !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mem: mem[0020]=%h expected 0000", mem[16'h0020]);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_write_read();
    drive(0, 1, 1, 0, 16'h0010, 16'hBEEF);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001 || mem_wrb !== 1'b0 || mem_address !== 16'h0010 || mem_data_in !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_bus: gnt=%b wrb=%b addr=%h data=%h expected 001 0 0010 beef",
               gnt, mem_wrb, mem_address, mem_data_in);
    end
    account(0);
    next_cycle();
    drive(0, 1, 0, 0, 16'h0010, 16'h0000);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001 || mem_wrb !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_bus: gnt=%b wrb=%b expected 001 1", gnt, mem_wrb);
    end
    account(0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 3'b001 || rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_return: rvalid=%b rdata=%h expected 001 beef", rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < N; i++) drive(i, 1, 0, 0, 16'h0100 + 16'(i), 16'h0000);
    shadow[16'h0100] = shadow[16'h0100];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== (3'b001 << (k % 3))) begin
        n_fail++;
        $display("FAIL rr_gnt step %0d: got %b expected %b", k, gnt, 3'b001 << (k % 3));
      end
      account(k % 3);
      next_cycle();
    end
    idle();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 1, 0, 16'h4002, 16'h5A5A);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b010) begin n_fail++; $display("FAIL b2b_preload: got %b expected 010", gnt); end
    account(1);
    next_cycle();
    drive(1, 1, 0, 0, 16'h4002, 16'h0000);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b010 || mem_wrb !== 1'b1 || mem_address !== 16'h4002) begin
      n_fail++;
      $display("FAIL b2b_read: gnt=%b wrb=%b addr=%h expected 010 1 4002", gnt, mem_wrb, mem_address);
    end
    account(1);
    next_cycle();
    drive(1, 0, 0, 0, 16'h0000, 16'h0000);
    drive(2, 1, 1, 0, 16'h0003, 16'hC0DE);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b100 || mem_wrb !== 1'b0 || mem_address !== 16'h0003 || mem_data_in !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL b2b_write: gnt=%b wrb=%b addr=%h data=%h expected 100 0 0003 c0de",
               gnt, mem_wrb, mem_address, mem_data_in);
    end
    n_checks++;
    if (rvalid !== 3'b010 || rdata !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL b2b_overlap: rvalid=%b rdata=%h expected 010 5a5a", rvalid, rdata);
    end
    account(2);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 3'b000) begin n_fail++; $display("FAIL b2b_no_rvalid: got %b expected 000", rvalid); end
    next_cycle();
  endtask

  task automatic test_single_requester();
    for (int k = 0; k < 4; k++) begin
      drive(2, 1, 0, 0, (k % 2 == 0) ? 16'h0003 : 16'h4002, 16'h0000);
      @(negedge clk);
      n_checks++;
      if (gnt !== 3'b100) begin
        n_fail++;
        $display("FAIL single_gnt step %0d: got %b expected 100", k, gnt);
      end
      account(2);
      next_cycle();
    end
    idle();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_withdraw();
    pulse_reset();
    drive(0, 1, 1, 0, 16'h0200, 16'h1111);
    drive(1, 1, 1, 0, 16'h0201, 16'h2222);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001) begin n_fail++; $display("FAIL wd_first: got %b expected 001", gnt); end
    account(0);
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b000 || mem_wrb !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_idle: gnt=%b wrb=%b expected 000 1", gnt, mem_wrb);
    end
    next_cycle();
    for (int i = 0; i < N; i++) drive(i, 1, 1, 0, 16'h0210 + 16'(i), 16'h3000 + 16'(i));
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b010) begin n_fail++; $display("FAIL wd_ptr_kept: got %b expected 010", gnt); end
    account(1);
    next_cycle();
    idle();
  endtask

  task automatic test_lock();
    int exp_seq[8];
`ifdef MEMARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 1, 16'h0300, 16'h0A00 + 16'(k));
      drive(1, 1, 1, 0, 16'h0301, 16'h0B00 + 16'(k));
      @(negedge clk);
      n_checks++;
      if (gnt !== (3'b001 << exp_seq[k])) begin
        n_fail++;
        $display("FAIL lock_gnt step %0d: got %b expected %b", k, gnt, 3'b001 << exp_seq[k]);
      end
      account(exp_seq[k]);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 1, 0, 0, 16'h4002, 16'h0000);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b010) begin n_fail++; $display("FAIL rmr_gnt: got %b expected 010", gnt); end
    account(1);
    next_cycle();
    rst = 1'b1;
    idle();
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rmr_rvalid: got %b expected 000", rvalid); end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, 1, 0, 0, 16'h0010, 16'h0000);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001) begin n_fail++; $display("FAIL rmr_ptr: got %b expected 001", gnt); end
    account(0);
    next_cycle();
    idle();
    @(negedge clk);
    next_cycle();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]    = '0;
      shadow[a] = '0;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_single_requester();
    test_withdraw();
    test_lock();
    test_reset_mid_read();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
